// File: rtl/sample_fetch_buffer.sv
// Fetches NUM_CH samples per conversion-done strobe from a latency-RD_LAT RAM into a shadow
// bank, then publishes the whole frame at once; also reads and classifies one diagnostic word.
module sample_fetch_buffer #(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned DATA_W    = 22,
  parameter int unsigned RAM_W     = 24,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned DIAG_ADDR = 6,
  parameter int unsigned DIAG_W    = 14
) (
  input  logic                     clk,
  input  logic                     in_reset_n,
  input  logic [1:0]               in_data_control,
  input  logic                     in_strm_dn,
  input  logic [RAM_W-1:0]         in_strm_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [NUM_CH*DATA_W-1:0] out_samples,
  output logic                     new_samples,
  output logic [1:0]               out_diag_er,
  output logic [DIAG_W-1:0]        out_er_data,
  output logic                     out_overrun
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitDn   = 3'd1;
  localparam logic [2:0] StFetch    = 3'd2;
  localparam logic [2:0] StDone     = 3'd3;
  localparam logic [2:0] StDiagRd   = 3'd4;
  localparam logic [2:0] StDiagHold = 3'd5;

  localparam logic [1:0] ModeClr  = 2'b00;
  localparam logic [1:0] ModeDiag = 2'b01;
  localparam logic [1:0] ModeStrm = 2'b10;
  localparam logic [1:0] ModeHold = 2'b11;

  localparam logic [2:0]        LastSlot = 3'(RD_LAT);
  localparam logic [ADDR_W-1:0] LastCh   = ADDR_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] DiagAddr = ADDR_W'(DIAG_ADDR);

  logic [2:0]               state_q, state_d;
  logic [ADDR_W-1:0]        ch_q, ch_d;
  logic [2:0]               slot_q, slot_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [NUM_CH*DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_CH*DATA_W-1:0] samples_q, samples_d;
  logic                     new_q, new_d;
  logic [1:0]               diag_er_q, diag_er_d;
  logic [DIAG_W-1:0]        er_data_q, er_data_d;
  logic                     overrun_q, overrun_d;

  // Upper RAM bits are intentionally dropped.
  logic data_unused;
  assign data_unused = ^in_strm_data;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    slot_d    = slot_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    samples_d = samples_q;
    new_d     = 1'b0;
    diag_er_d = diag_er_q;
    er_data_d = er_data_q;
    overrun_d = overrun_q;

    if (in_data_control == ModeHold) begin
      new_d = new_q;
    end else if (in_data_control == ModeClr) begin
      state_d   = StIdle;
      ch_d      = '0;
      slot_d    = '0;
      addr_d    = '0;
      shadow_d  = '0;
      samples_d = '0;
      diag_er_d = 2'b00;
      er_data_d = '0;
      overrun_d = 1'b0;
    end else begin
      if ((state_q == StFetch || state_q == StDone) && in_strm_dn) overrun_d = 1'b1;
      case (state_q)
        StIdle, StWaitDn: begin
          addr_d = '0;
          if (in_data_control == ModeDiag) begin
            state_d = StDiagRd;
            addr_d  = DiagAddr;
            slot_d  = '0;
          end else if (state_q == StWaitDn && in_strm_dn) begin
            state_d = StFetch;
            ch_d    = '0;
            slot_d  = '0;
          end else begin
            state_d = StWaitDn;
          end
        end
        StFetch: begin
          if (in_data_control == ModeDiag) begin
            // Abort: shadow contents are simply never published.
            state_d = StDiagRd;
            addr_d  = DiagAddr;
            slot_d  = '0;
            ch_d    = '0;
          end else if (slot_q == LastSlot) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
              if (ch_q == ADDR_W'(k)) shadow_d[k*DATA_W +: DATA_W] = in_strm_data[DATA_W-1:0];
            end
            slot_d = '0;
            if (ch_q == LastCh) begin
              state_d   = StDone;
              samples_d = shadow_d;
              new_d     = 1'b1;
              addr_d    = '0;
              ch_d      = '0;
            end else begin
              ch_d   = ch_q + 1'b1;
              addr_d = ch_q + 1'b1;
            end
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
        StDone: begin
          if (in_data_control == ModeDiag) begin
            state_d = StDiagRd;
            addr_d  = DiagAddr;
            slot_d  = '0;
          end else begin
            state_d = StWaitDn;
            addr_d  = '0;
          end
        end
        StDiagRd: begin
          if (in_data_control == ModeStrm) begin
            state_d = StWaitDn;
            addr_d  = '0;
            slot_d  = '0;
          end else if (slot_q == LastSlot) begin
            er_data_d = in_strm_data[DIAG_W-1:0];
            diag_er_d = (in_strm_data[DIAG_W-1:0] == '0) ? 2'b10 : 2'b01;
            state_d   = StDiagHold;
            slot_d    = '0;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
        StDiagHold: begin
          if (in_data_control == ModeStrm) begin
            state_d = StWaitDn;
            addr_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!in_reset_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      slot_q    <= '0;
      addr_q    <= '0;
      shadow_q  <= '0;
      samples_q <= '0;
      new_q     <= 1'b0;
      diag_er_q <= 2'b00;
      er_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      slot_q    <= slot_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      samples_q <= samples_d;
      new_q     <= new_d;
      diag_er_q <= diag_er_d;
      er_data_q <= er_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_addr    = addr_q;
  assign out_samples = samples_q;
  assign new_samples = new_q;
  assign out_diag_er = diag_er_q;
  assign out_er_data = er_data_q;
  assign out_overrun = overrun_q;

endmodule
